ysyx_22040729_alu_multiplier_seq: RTL and testbench

- Iterative radix-2 shift-add multiplier; the multiply counterpart of the ALU divider.
- Serves RV64M MUL/MULH/MULHSU/MULHU/MULW.
- Takes one operand pair through a valid/ready handshake and computes the full 2*XLEN-bit product over XLEN cycles.
- Returns the product through a valid/ready handshake to the EXU. Unused bits are sliced and sign-extended outside the block.

---
 rtl/ysyx_22040729_mul_pkg.sv | 19 +
 rtl/ysyx_22040729_mul_absneg.sv | 16 +
 rtl/ysyx_22040729_alu_multiplier_seq.sv | 157 +++++++++++++++
 tb/tb_ysyx_22040729_alu_multiplier_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040729_mul_pkg.sv
// rtl/ysyx_22040729_mul_pkg.sv - shared types and constants for the sequential multiplier
// Contents: default operand width, FSM state type, signedness encodings for the EXU decoder.
package ysyx_22040729_mul_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Encoded as {in_a_signed, in_b_signed}.
    // MUL/MULW/MULHU -> MUL_UU, MULHSU -> MUL_SU, MULH -> MUL_SS.
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;

endpackage

// File: rtl/ysyx_22040729_mul_absneg.sv
// rtl/ysyx_22040729_mul_absneg.sv - combinational conditional two's-complement negate
// Ports:
//   i_data [W-1:0]  value in
//   i_neg           negate when high
//   o_data [W-1:0]  i_neg ? -i_data : i_data (wraps modulo 2^W)
module ysyx_22040729_mul_absneg #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_data,
    input  logic         i_neg,
    output logic [W-1:0] o_data
);

    assign o_data = i_neg ? (~i_data + W'(1)) : i_data;

endmodule

// File: rtl/ysyx_22040729_alu_multiplier_seq.sv
// rtl/ysyx_22040729_alu_multiplier_seq.sv - iterative radix-2 shift-add multiplier for RV64M
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             operand handshake (in_ready only in IDLE)
//   in_a, in_b                    multiplicand, multiplier (XLEN)
//   in_a_signed, in_b_signed      operand is two's complement
//   flush                         abort current operation, return to IDLE
//   out_valid/out_ready           result handshake
//   out_result                    full 2*XLEN product
//   busy                          state != IDLE
// Optional: define YSYX_22040729_MUL_EARLY_OUT_EN to finish as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module ysyx_22040729_alu_multiplier_seq
    import ysyx_22040729_mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic              in_a_signed,
    input  logic              in_b_signed,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*XLEN-1:0] out_result,
    output logic              busy
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int PW    = 2 * XLEN;

    mul_state_e       r_state;
    mul_state_e       w_state_next;

    // r_ma holds the magnitude of a pre-shifted by the iteration count, so the
    // per-cycle add never needs a variable shifter.
    logic [PW-1:0]    r_ma;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_result;
    logic [XLEN-1:0]  r_mb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN-1:0]  w_mb_next;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_result;
    logic             w_accept;
    logic             w_last;

    assign w_a_neg = in_a_signed & in_a[XLEN-1];
    assign w_b_neg = in_b_signed & in_b[XLEN-1];

    // The most-negative input maps to 2^(XLEN-1), which fits as an unsigned magnitude.
    ysyx_22040729_mul_absneg #(.W(XLEN)) u_abs_a (
        .i_data (in_a),
        .i_neg  (w_a_neg),
        .o_data (w_a_mag)
    );

    ysyx_22040729_mul_absneg #(.W(XLEN)) u_abs_b (
        .i_data (in_b),
        .i_neg  (w_b_neg),
        .o_data (w_b_mag)
    );

    assign w_mb_next  = r_mb >> 1;
    assign w_acc_next = r_acc + (r_mb[0] ? r_ma : '0);

`ifdef YSYX_22040729_MUL_EARLY_OUT_EN
    assign w_last = (r_cnt == CNT_W'(XLEN - 1)) || (w_mb_next == '0);
`else
    assign w_last = (r_cnt == CNT_W'(XLEN - 1));
`endif

    // Sign correction is applied to the final accumulation value, in the same
    // cycle the last partial product is added.
    ysyx_22040729_mul_absneg #(.W(PW)) u_fix (
        .i_data (w_acc_next),
        .i_neg  (r_neg),
        .o_data (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = CALC;
                    end
                end
                CALC: begin
                    if (w_last) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_ma     <= PW'(w_a_mag);
            r_mb     <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_a_neg ^ w_b_neg;
        end else if (r_state == CALC && !flush) begin
            r_acc    <= w_acc_next;
            r_ma     <= r_ma << 1;
            r_mb     <= w_mb_next;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_result;
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign out_result = r_result;

endmodule

// File: tb/tb_ysyx_22040729_alu_multiplier_seq.sv
// tb/tb_ysyx_22040729_alu_multiplier_seq.sv - scoreboard bench for the sequential multiplier
module tb_ysyx_22040729_alu_multiplier_seq;

    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   in_a = '0;
    logic [XLEN-1:0]   in_b = '0;
    logic              in_a_signed = 1'b0;
    logic              in_b_signed = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*XLEN-1:0] out_result;
    logic              busy;

    ysyx_22040729_alu_multiplier_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_a_signed (in_a_signed),
        .in_b_signed (in_b_signed),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] res;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           rise_cyc = 0;
    bit           pending = 1'b0;
    bit           prev_valid = 1'b0;
    bit           hold = 1'b0;
    logic [127:0] prev_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] ref_mul(logic [63:0] a, logic [63:0] b, bit sa, bit sbf);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = sa  ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sbf ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic int ref_lat(logic [63:0] b, bit sbf);
`ifdef YSYX_22040729_MUL_EARLY_OUT_EN
        logic [63:0] m;
        int          l;
        m = (sbf && b[63]) ? (64'd0 - b) : b;
        l = 1;
        for (int i = 0; i < 64; i++) if (m[i]) l = i + 1;
        return l;
`else
        return (b[0] | sbf) ? XLEN : XLEN;
`endif
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("in_ready_vs_outstanding", {127'd0, in_ready}, {127'd0, !pending});
            if (hold) begin
                check("hold_out_valid", {127'd0, out_valid}, 128'd1);
                check("hold_out_result", out_result, prev_res);
            end
            if (in_valid && in_ready && !flush) acc_cyc = cyc + 1;
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no result", out_result);
                end else begin
                    e = sb.pop_front();
                    check("result", out_result, e.res);
                    check("latency", 128'(rise_cyc - acc_cyc), 128'(e.lat));
                end
                pending = 1'b0;
            end
            hold       = out_valid && !out_ready && !flush;
            prev_res   = out_result;
            prev_valid = out_valid;
        end else begin
            hold       = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [63:0] a, logic [63:0] b, bit sa, bit sbf);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        in_a = a; in_b = b; in_a_signed = sa; in_b_signed = sbf; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Scramble inputs after the accept edge; the DUT must ignore them.
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_a_signed = 1'($urandom); in_b_signed = 1'($urandom);
        e.res = ref_mul(a, b, sa, sbf);
        e.lat = ref_lat(b, sbf);
        sb.push_back(e);
        pending = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        int t;
        t = 0;
        while (!out_valid && t < 300) begin
            step();
            t++;
        end
        ok = out_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
            rst = 1'b1; step(); rst = 1'b0;
            sb.delete();
            pending = 1'b0;
        end
    endtask

    task automatic do_op(logic [63:0] a, logic [63:0] b, bit sa, bit sbf, int hold_n);
        bit ok;
        issue(a, b, sa, sbf);
        wait_valid(ok);
        if (ok) begin
            repeat (hold_n) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("idle_after_consume", {127'd0, in_ready}, 128'd1);
        end
    endtask

    task automatic abort_mid_calc(bit use_rst);
        issue({$urandom, $urandom}, {1'b1, 31'($urandom), $urandom}, 1'b0, 1'b0);
        repeat (19) step();
        check("busy_mid_calc", {127'd0, busy}, 128'd1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        sb.delete();
        pending = 1'b0;
        check(use_rst ? "in_ready_after_rst" : "in_ready_after_flush", {127'd0, in_ready}, 128'd1);
        check("out_valid_after_abort", {127'd0, out_valid}, 128'd0);
        repeat (80) step();
        do_op(64'd7, 64'd6, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bit ok;
        repeat (3) step();
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_out_result", out_result, 128'd0);
        rst = 1'b0;
        step();

        do_op(64'd3, 64'd5, 1'b0, 1'b0, 0);
        do_op('1, '1, 1'b1, 1'b1, 0);
        do_op('1, '1, 1'b1, 1'b0, 1);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 0);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
        do_op(64'd7, 64'd1, 1'b0, 1'b0, 0);
        do_op(64'd7, 64'd0, 1'b0, 1'b0, 0);
        do_op(64'd7, 64'd0, 1'b1, 1'b1, 0);
        do_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 0);
        do_op(64'd2, 64'd2, 1'b1, 1'b1, 0);
        do_op(64'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 0);

        // Backpressure: hold out_ready low for 10 cycles after out_valid.
        do_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 10);

        // Flush together with in_valid in IDLE: no accept.
        in_a = 64'd9; in_b = 64'd9; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", {127'd0, busy}, 128'd0);
        check("flush_idle_in_ready", {127'd0, in_ready}, 128'd1);

        abort_mid_calc(1'b0);
        abort_mid_calc(1'b1);

        // Flush in DONE with out_ready high: result consumed, back to IDLE.
        issue(64'd11, 64'd13, 1'b0, 1'b0);
        wait_valid(ok);
        if (ok) begin
            flush = 1'b1; out_ready = 1'b1;
            step();
            flush = 1'b0; out_ready = 1'b0;
            check("flush_done_in_ready", {127'd0, in_ready}, 128'd1);
        end

        for (int i = 0; i < 24; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) rb = rb >> $urandom_range(63, 0);
            if (i % 4 == 2) ra = ra >> $urandom_range(63, 0);
            do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
        end

        repeat (3) step();
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
